// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// clear-engine state encoding and the packed-port slice helper.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_t;

  // Low bit of port k inside a packed bus of w-bit fields.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Bulk-clear sequencer: sweeps a pointer over every clearable address and
// reports busy, clear_done and dropped-write status to the register file.
import reg_file_pkg::*;

module reg_file_clear_fsm #(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              clear_done,
  output logic              wr_dropped,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] FIRST  = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST   = '1;
  localparam logic [ADDR_W-1:0] PENULT = LAST - ADDR_W'(1);

  clear_state_t      state;
  logic [ADDR_W-1:0] ptr;

  // clear_done is registered one step ahead so it lines up with the final sweep cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      wr_dropped <= busy && wr_req;
      case (state)
        ST_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state      <= ST_CLEAR;
            ptr        <= FIRST;
            busy       <= 1'b1;
            clear_done <= (FIRST == LAST);
          end
        end
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
          end else begin
            ptr        <= ptr + ADDR_W'(1);
            clear_done <= (ptr == PENULT);
          end
        end
        default: begin
          state      <= ST_IDLE;
          ptr        <= '0;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with two prioritised write ports and a
// bulk-clear engine. Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
import reg_file_pkg::*;

module reg_file_mp #(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     clear_done,
  output logic                     wr_dropped
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr0_valid;
  logic              wr1_valid;

  // Writes to a hardwired zero register are not real writes, so they never count as dropped.
  assign wr0_valid = we0 && !(HAS_ZERO && wa0 == '0);
  assign wr1_valid = we1 && !(HAS_ZERO && wa1 == '0);

  reg_file_clear_fsm #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_clear_fsm (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .wr_req     (wr0_valid || wr1_valid),
    .busy       (busy),
    .clear_done (clear_done),
    .wr_dropped (wr_dropped),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr0_valid) begin
        mem[wa0] <= wd0;
      end
      if (wr1_valid) begin
        mem[wa1] <= wd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];

    always_comb begin
      val = mem[addr];
      if (HAS_ZERO && addr == '0) begin
        val = '0;
      end
`ifdef REG_FILE_BYPASS_EN
      if (wr0_valid && !busy && wa0 == addr) begin
        val = wd0;
      end
      if (wr1_valid && !busy && wa1 == addr) begin
        val = wd1;
      end
`endif
    end

    assign rd_data[slice_lo(k, DATA_W) +: DATA_W] = val;
  end

endmodule
